// File: rtl/alu_seq_pkg.sv
// Shared types for the nibble-serial ALU sequencer: FSM states, common S codes,
// and the bitwise (M=1) function table of the 4-bit slice.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] ALU_S_ADD    = 4'b1001;  // M=0: A + B + cin
    localparam logic [3:0] ALU_S_SUB    = 4'b0110;  // M=0: A - B - 1 + cin
    localparam logic [3:0] ALU_S_PASS_A = 4'b0000;  // M=0: A + cin
    localparam logic [3:0] ALU_S_DOUBLE = 4'b1100;  // M=0: A + A + cin
    localparam logic [3:0] ALU_S_XOR    = 4'b0110;  // M=1
    localparam logic [3:0] ALU_S_AND    = 4'b1011;  // M=1

    function automatic logic [3:0] alu_logic(input logic [3:0] s,
                                             input logic [3:0] a,
                                             input logic [3:0] b);
        logic [3:0] f;
        case (s)
            4'b0000: f = ~a;
            4'b0001: f = ~(a | b);
            4'b0010: f = ~a & b;
            4'b0011: f = 4'b0000;
            4'b0100: f = ~(a & b);
            4'b0101: f = ~b;
            4'b0110: f = a ^ b;
            4'b0111: f = a & ~b;
            4'b1000: f = ~a | b;
            4'b1001: f = ~(a ^ b);
            4'b1010: f = b;
            4'b1011: f = a & b;
            4'b1100: f = 4'b1111;
            4'b1101: f = a | ~b;
            4'b1110: f = a | b;
            default: f = a;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/alu_74181.sv
// Combinational 4-bit 74181-style slice, active-high data, cin = +1.
// Each arithmetic function is expressed as the sum of two operand terms plus cin.
module alu_74181
    import alu_seq_pkg::*;
(
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic [3:0] s_i,
    input  logic       m_i,
    input  logic       cin_i,
    output logic [3:0] f_o,
    output logic       cout_o
);

    logic [3:0] p;
    logic [3:0] q;
    logic [4:0] sum;

    // "minus 1" terms are an addend of all ones, which also yields the chip's carry behaviour
    always_comb begin
        p = a_i;
        q = 4'b0000;
        case (s_i)
            4'b0000: begin p = a_i;          q = 4'b0000;     end
            4'b0001: begin p = a_i | b_i;    q = 4'b0000;     end
            4'b0010: begin p = a_i | ~b_i;   q = 4'b0000;     end
            4'b0011: begin p = 4'b0000;      q = 4'b1111;     end
            4'b0100: begin p = a_i;          q = a_i & ~b_i;  end
            4'b0101: begin p = a_i | b_i;    q = a_i & ~b_i;  end
            4'b0110: begin p = a_i;          q = ~b_i;        end
            4'b0111: begin p = a_i & ~b_i;   q = 4'b1111;     end
            4'b1000: begin p = a_i;          q = a_i & b_i;   end
            4'b1001: begin p = a_i;          q = b_i;         end
            4'b1010: begin p = a_i | ~b_i;   q = a_i & b_i;   end
            4'b1011: begin p = a_i & b_i;    q = 4'b1111;     end
            4'b1100: begin p = a_i;          q = a_i;         end
            4'b1101: begin p = a_i | b_i;    q = a_i;         end
            4'b1110: begin p = a_i | ~b_i;   q = a_i;         end
            default: begin p = a_i;          q = 4'b1111;     end
        endcase
        sum    = {1'b0, p} + {1'b0, q} + {4'b0000, cin_i};
        f_o    = m_i ? alu_logic(s_i, a_i, b_i) : sum[3:0];
        cout_o = m_i ? 1'b0 : sum[4];
    end

endmodule

// File: rtl/alu_nibble_sequencer.sv
// Runs one WIDTH-bit op through a 4-bit slice, one nibble per cycle; response valid NIBBLES
// cycles after accept; one op in flight, request held off (ready=0) until the response is taken.
module alu_nibble_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [3:0]       req_s_i,
    input  logic             req_m_i,
    input  logic             req_cin_i,
    input  logic [WIDTH-1:0] req_a_i,
    input  logic [WIDTH-1:0] req_b_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_f_o,
    output logic             rsp_cout_o,
    output logic             rsp_eq_o,
    output logic             busy_o
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIBBLES - 1);

    state_t            state_q;
    logic [IDXW-1:0]   idx_q;
    logic              carry_q;
    logic [3:0]        s_q;
    logic              m_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  result_q;
    logic              cout_q;
    logic              ready_q;
    logic              valid_q;
    logic              busy_q;

    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic [3:0]        slice_f;
    logic              slice_cout;
    logic              carry_d;

    assign a_sh    = a_q >> {idx_q, 2'b00};
    assign b_sh    = b_q >> {idx_q, 2'b00};
    assign carry_d = m_q ? 1'b0 : slice_cout;

    alu_74181 u_slice (
        .a_i    (a_sh[3:0]),
        .b_i    (b_sh[3:0]),
        .s_i    (s_q),
        .m_i    (m_q),
        .cin_i  (carry_q),
        .f_o    (slice_f),
        .cout_o (slice_cout)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            s_q      <= 4'b0000;
            m_q      <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        s_q      <= req_s_i;
                        m_q      <= req_m_i;
                        a_q      <= req_a_i;
                        b_q      <= req_b_i;
                        carry_q  <= req_cin_i;
                        idx_q    <= '0;
                        result_q <= '0;
                        cout_q   <= 1'b0;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    result_q[4*idx_q +: 4] <= slice_f;
                    carry_q                <= carry_d;
                    idx_q                  <= idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        idx_q   <= '0;
                        cout_q  <= carry_d;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready_i) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = valid_q;
    assign busy_o      = busy_q;
    assign rsp_f_o     = result_q;
    assign rsp_cout_o  = cout_q;
    assign rsp_eq_o    = &result_q;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer (WIDTH=16): vector table plus reset, backpressure and abort sequences.
module tb_alu_nibble_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [3:0]  req_s_i = 4'b0000;
    logic        req_m_i = 1'b0;
    logic        req_cin_i = 1'b0;
    logic [15:0] req_a_i = 16'h0000;
    logic [15:0] req_b_i = 16'h0000;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b1;
    logic [15:0] rsp_f_o;
    logic        rsp_cout_o;
    logic        rsp_eq_o;
    logic        busy_o;

    alu_nibble_sequencer #(.WIDTH(16)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_s_i     (req_s_i),
        .req_m_i     (req_m_i),
        .req_cin_i   (req_cin_i),
        .req_a_i     (req_a_i),
        .req_b_i     (req_b_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_f_o     (rsp_f_o),
        .rsp_cout_o  (rsp_cout_o),
        .rsp_eq_o    (rsp_eq_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic [3:0]  s;
        logic        m;
        logic        cin;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] f;
        logic        cout;
        logic        eq;
    } vec_t;

    vec_t vecs[10];
    vec_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Scoreboard: pop the oldest expectation on every response handshake cycle
    always @(negedge clk_i) begin
        if (!rst_i && rsp_valid_o && rsp_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 32'(exp_q.size()), 1);
            end else begin
                vec_t e;
                e = exp_q.pop_front();
                chk({e.name, "_f"}, rsp_f_o, e.f);
                chk({e.name, "_cout"}, rsp_cout_o, e.cout);
                chk({e.name, "_eq"}, rsp_eq_o, e.eq);
            end
        end
    end

    task automatic drive(input vec_t v);
        req_s_i     = v.s;
        req_m_i     = v.m;
        req_cin_i   = v.cin;
        req_a_i     = v.a;
        req_b_i     = v.b;
        req_valid_i = 1'b1;
    endtask

    // Issue one op, check latency; returns #1 after the edge where rsp_valid rose
    task automatic send(input vec_t v);
        int n;
        exp_q.push_back(v);
        @(negedge clk_i);
        drive(v);
        n = 0;
        while (!req_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        chk({v.name, "_accept"}, req_ready_o, 1);
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        req_a_i     = 16'($urandom);
        req_b_i     = 16'($urandom);
        req_s_i     = 4'($urandom);
        req_cin_i   = 1'($urandom);
        n = 0;
        while (!rsp_valid_o && n < 20) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        chk({v.name, "_latency"}, n, 4);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        chk("drain", 32'(exp_q.size()), 0);
    endtask

    initial begin
        int   seen;
        vec_t v;

        vecs[0] = '{"add_carry_chain", 4'b1001, 1'b0, 1'b0, 16'h0FFF, 16'h0001, 16'h1000, 1'b0, 1'b0};
        vecs[1] = '{"add_wrap",        4'b1001, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{"sub_cin1_equal",  4'b0110, 1'b0, 1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0};
        vecs[3] = '{"sub_cin0_equal",  4'b0110, 1'b0, 1'b0, 16'h1234, 16'h1234, 16'hFFFF, 1'b0, 1'b1};
        vecs[4] = '{"xor_cin_ignored", 4'b0110, 1'b1, 1'b1, 16'hA5A5, 16'hFFFF, 16'h5A5A, 1'b0, 1'b0};
        vecs[5] = '{"and_logic",       4'b1011, 1'b1, 1'b0, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0};
        vecs[6] = '{"sub_borrow",      4'b0110, 1'b0, 1'b1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0};
        vecs[7] = '{"inc_a",           4'b0000, 1'b0, 1'b1, 16'hFFFF, 16'h1234, 16'h0000, 1'b1, 1'b0};
        vecs[8] = '{"double_a",        4'b1100, 1'b0, 1'b0, 16'h8001, 16'h0000, 16'h0002, 1'b1, 1'b0};
        vecs[9] = '{"add_cin1",        4'b1001, 1'b0, 1'b1, 16'h1234, 16'h4321, 16'h5556, 1'b0, 1'b0};

        // Asynchronous reset, checked before the first clock edge
        #2 rst_i = 1'b1;
        #1;
        chk("rst_req_ready", req_ready_o, 1);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_rsp_f", rsp_f_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_cout", rsp_cout_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < 10; i++) begin
            send(vecs[i]);
            drain();
        end

        // Backpressure: response held 3 cycles while a new request waits
        rsp_ready_i = 1'b0;
        send(vecs[0]);
        v = vecs[4];
        v.name = "xor_after_bp";
        exp_q.push_back(v);
        drive(v);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("bp_rsp_valid", rsp_valid_o, 1);
            chk("bp_rsp_f_stable", rsp_f_o, 16'h1000);
            chk("bp_req_ready", req_ready_o, 0);
        end
        @(posedge clk_i);
        #1 rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("bp_idle_ready", req_ready_o, 1);
        chk("bp_idle_valid", rsp_valid_o, 0);
        @(posedge clk_i);
        #1;
        chk("bp_next_accepted", req_ready_o, 0);
        chk("bp_next_busy", busy_o, 1);
        req_valid_i = 1'b0;
        drain();

        // Reset two cycles into an op: aborted, no response
        @(negedge clk_i);
        drive(vecs[1]);
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #3 rst_i = 1'b1;
        #1;
        chk("abort_req_ready", req_ready_o, 1);
        chk("abort_rsp_valid", rsp_valid_o, 0);
        chk("abort_rsp_f", rsp_f_o, 0);
        chk("abort_busy", busy_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o) seen = 1;
        end
        chk("abort_no_rsp", seen, 0);

        v = '{"add_after_abort", 4'b1001, 1'b0, 1'b0, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0};
        send(v);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
